// File: rtl/led_light.sv
// Two-LED status pattern generator: a prescaler tick drives a step counter that
// walks through alternate, synchronous-blink and binary-count patterns.
module led_light #(
  parameter int CNT_MAX        = 24_999_999,
  parameter int STEPS_PER_MODE = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic [1:0] led
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int SW = $clog2(STEPS_PER_MODE);

  typedef enum logic [1:0] {
    ALT   = 2'd0,
    SYNC  = 2'd1,
    COUNT = 2'd2
  } mode_t;

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [SW-1:0] step;
  logic [SW-1:0] step_nxt;
  mode_t         mode;
  mode_t         mode_nxt;
  logic [1:0]    led_nxt;

  assign tick = (div_cnt == CW'(CNT_MAX));

  // Next step/mode as they will be after a tick; led is loaded from these.
  always_comb begin
    step_nxt = step;
    mode_nxt = mode;
    case (mode)
      ALT, SYNC, COUNT: begin
        if (step == SW'(STEPS_PER_MODE - 1)) begin
          step_nxt = '0;
          case (mode)
            ALT:     mode_nxt = SYNC;
            SYNC:    mode_nxt = COUNT;
            default: mode_nxt = ALT;
          endcase
        end else begin
          step_nxt = step + SW'(1);
        end
      end
      default: begin
        step_nxt = '0;
        mode_nxt = ALT;
      end
    endcase
  end

  always_comb begin
    led_nxt = 2'b01;
    case (mode_nxt)
      ALT:     led_nxt = step_nxt[0] ? 2'b10 : 2'b01;
      SYNC:    led_nxt = step_nxt[0] ? 2'b00 : 2'b11;
      COUNT:   led_nxt = step_nxt[1:0];
      default: led_nxt = 2'b01;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      step    <= '0;
      mode    <= ALT;
      led     <= 2'b01;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      if (tick) begin
        step <= step_nxt;
        mode <= mode_nxt;
        led  <= led_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_light.sv
// Self-checking bench for led_light: two parameterisations compared every cycle
// against an elapsed-time model, with randomised asynchronous resets.
module tb_led_light;

  localparam int unsigned CA = 4;
  localparam int unsigned SA = 4;
  localparam int unsigned CB = 1;
  localparam int unsigned SB = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] led_a;
  logic [1:0] led_b;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned edges = 0;

  led_light #(.CNT_MAX(CA), .STEPS_PER_MODE(SA)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .led(led_a)
  );

  led_light #(.CNT_MAX(CB), .STEPS_PER_MODE(SB)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .led(led_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edges=%0d, t=%0t)", tag, got, exp, edges, $time);
    end
  endtask

  // Pattern as a function of rising edges elapsed since reset release.
  function automatic logic [1:0] ref_led(int unsigned n, int unsigned cmax, int unsigned spm);
    int unsigned t, s, m;
    t = n / (cmax + 1);
    s = t % spm;
    m = (t / spm) % 3;
    case (m)
      0:       return (s % 2) ? 2'b10 : 2'b01;
      1:       return (s % 2) ? 2'b00 : 2'b11;
      default: return 2'((s % 4));
    endcase
  endfunction

  task automatic check_all();
    check("led_a", 32'(led_a), 32'(ref_led(edges, CA, SA)));
    check("led_b", 32'(led_b), 32'(ref_led(edges, CB, SB)));
    check("div_a", 32'(dut.div_cnt), edges % (CA + 1));
    check("tick_a", 32'(dut.tick), 32'((edges % (CA + 1)) == CA));
    check("div_b", 32'(dut2.div_cnt), edges % (CB + 1));
  endtask

  task automatic run_edges(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edges++;
      check_all();
    end
  endtask

  task automatic async_reset();
    #($urandom_range(2, 15));
    rst_n = 1'b0;
    #1;
    check("rst_led_a", 32'(led_a), 32'h1);
    check("rst_led_b", 32'(led_b), 32'h1);
    check("rst_div_a", 32'(dut.div_cnt), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_led_a", 32'(led_a), 32'h1);
    check("hold_div_a", 32'(dut.div_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("por_led_a", 32'(led_a), 32'h1);
      check("por_led_b", 32'(led_b), 32'h1);
      check("por_div_a", 32'(dut.div_cnt), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;

    // Full pattern twice plus one tick, then stop in SYNC with led=11.
    run_edges(2 * 3 * SA * (CA + 1) + (CA + 1));
    async_reset();
    run_edges(4 * (CA + 1) + 2);
    check("sync_11", 32'(led_a), 32'h3);
    async_reset();
    run_edges(CA);
    check("pre_tick", 32'(led_a), 32'h1);
    run_edges(1);
    check("first_tick", 32'(led_a), 32'h2);

    for (int r = 0; r < 8; r++) begin
      run_edges($urandom_range(1, 150));
      async_reset();
    end
    run_edges(3 * SA * (CA + 1) + 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (edges=%0d)", edges);
    $fatal(1);
  end

endmodule
